// File: rtl/axis_axi_ram_writer_pkg.sv
// Shared definitions for the AXI-stream to AXI4 RAM writer: AXI encodings,
// writer state encoding and a small arithmetic helper.
package axis_axi_ram_writer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ADDR   = 3'd1,
      ST_DATA   = 3'd2,
      ST_WAIT_B = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   localparam logic [1:0] BURST_INCR      = 2'b01;
   localparam logic [1:0] RESP_OKAY       = 2'b00;
   localparam logic [3:0] AWCACHE_DEFAULT = 4'b0011;

   function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/axis_axi_ram_writer.sv
// Turns a (start address, beat count) command plus an AXI-stream payload into
// AXI4 INCR write bursts, split at MAX_BURST_LEN and 4 KB pages, then reports status.
module axis_axi_ram_writer
   import axis_axi_ram_writer_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 16,
   parameter int STRB_WIDTH    = DATA_WIDTH / 8,
   parameter int ID_WIDTH      = 8,
   parameter int AXI_ID        = 0,
   parameter int LEN_WIDTH     = 16,
   parameter int MAX_BURST_LEN = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] s_cmd_addr,
   input  logic [LEN_WIDTH-1:0]  s_cmd_len,
   input  logic                  s_cmd_valid,
   output logic                  s_cmd_ready,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [STRB_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   output logic [ID_WIDTH-1:0]   m_axi_awid,
   output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic [7:0]            m_axi_awlen,
   output logic [2:0]            m_axi_awsize,
   output logic [1:0]            m_axi_awburst,
   output logic                  m_axi_awlock,
   output logic [3:0]            m_axi_awcache,
   output logic [2:0]            m_axi_awprot,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [DATA_WIDTH-1:0] m_axi_wdata,
   output logic [STRB_WIDTH-1:0] m_axi_wstrb,
   output logic                  m_axi_wlast,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   input  logic [ID_WIDTH-1:0]   m_axi_bid,
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,
   output logic                  status_valid,
   output logic                  status_error,
   output logic                  status_tlast_mismatch
);

   localparam int AXSIZE = $clog2(STRB_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);
   localparam logic [LEN_WIDTH-1:0]  LEN_ONE    = LEN_WIDTH'(1);
   localparam logic [LEN_WIDTH:0]    OB_ONE     = (LEN_WIDTH + 1)'(1);

   state_t                state_r;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [LEN_WIDTH-1:0]  remaining_r;
   logic [8:0]            beat_cnt_r;
   logic [8:0]            burst_len_r;
   logic [LEN_WIDTH:0]    outstanding_r;
   logic                  error_r;
   logic                  mismatch_r;
   logic                  s_cmd_ready_r;
   logic                  awvalid_r;
   logic [ADDR_WIDTH-1:0] awaddr_r;
   logic [7:0]            awlen_r;
   logic                  bready_r;
   logic                  status_valid_r;
   logic                  status_error_r;
   logic                  status_mismatch_r;

   logic [12:0]           page_room_s;
   logic [8:0]            burst_s;
   logic [LEN_WIDTH:0]    outstanding_next_s;
   logic                  aw_hs_s;
   logic                  w_hs_s;
   logic                  b_hs_s;
   logic                  in_data_s;
   logic                  final_beat_s;

   assign in_data_s    = (state_r == ST_DATA);
   assign aw_hs_s      = awvalid_r && m_axi_awready;
   assign w_hs_s       = in_data_s && s_axis_tvalid && m_axi_wready;
   assign b_hs_s       = bready_r && m_axi_bvalid;
   assign final_beat_s = (remaining_r == LEN_ONE);

   // Next burst size: remaining beats, capped by the burst limit and the room left in the 4 KB page.
   always_comb begin
      page_room_s = (13'd4096 - {1'b0, addr_r[11:0]}) >> AXSIZE;
      burst_s     = 9'(min_u32(min_u32(32'(remaining_r), 32'(MAX_BURST_LEN)), 32'(page_room_s)));
   end

   // Outstanding B count; a simultaneous AW and B handshake cancel out.
   always_comb begin
      outstanding_next_s = outstanding_r;
      if (aw_hs_s && !b_hs_s) begin
         outstanding_next_s = outstanding_r + OB_ONE;
      end else if (!aw_hs_s && b_hs_s) begin
         outstanding_next_s = outstanding_r - OB_ONE;
      end else begin
         outstanding_next_s = outstanding_r;
      end
   end

   // Writer FSM with all control outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r           <= ST_IDLE;
         addr_r            <= '0;
         remaining_r       <= '0;
         beat_cnt_r        <= 9'd0;
         burst_len_r       <= 9'd0;
         outstanding_r     <= '0;
         error_r           <= 1'b0;
         mismatch_r        <= 1'b0;
         s_cmd_ready_r     <= 1'b0;
         awvalid_r         <= 1'b0;
         awaddr_r          <= '0;
         awlen_r           <= 8'd0;
         bready_r          <= 1'b0;
         status_valid_r    <= 1'b0;
         status_error_r    <= 1'b0;
         status_mismatch_r <= 1'b0;
      end else begin
         status_valid_r <= 1'b0;
         outstanding_r  <= outstanding_next_s;
         if (b_hs_s) begin
            error_r <= error_r | (m_axi_bresp != RESP_OKAY);
         end
         case (state_r)
            ST_IDLE: begin
               if (s_cmd_ready_r && s_cmd_valid) begin
                  s_cmd_ready_r <= 1'b0;
                  addr_r        <= s_cmd_addr & ~ALIGN_MASK;
                  remaining_r   <= s_cmd_len;
                  error_r       <= 1'b0;
                  mismatch_r    <= 1'b0;
                  bready_r      <= 1'b1;
                  state_r       <= (s_cmd_len == '0) ? ST_DONE : ST_ADDR;
               end else begin
                  s_cmd_ready_r <= 1'b1;
               end
            end
            ST_ADDR: begin
               // First cycle loads the AW fields; they then stay frozen until awready.
               if (!awvalid_r) begin
                  awvalid_r   <= 1'b1;
                  awaddr_r    <= addr_r;
                  awlen_r     <= 8'(burst_s - 9'd1);
                  burst_len_r <= burst_s;
               end else if (m_axi_awready) begin
                  awvalid_r  <= 1'b0;
                  beat_cnt_r <= burst_len_r;
                  state_r    <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_hs_s) begin
                  beat_cnt_r  <= beat_cnt_r - 9'd1;
                  remaining_r <= remaining_r - LEN_ONE;
                  if (s_axis_tlast != final_beat_s) begin
                     mismatch_r <= 1'b1;
                  end
                  if (beat_cnt_r == 9'd1) begin
                     addr_r  <= addr_r + (ADDR_WIDTH'(burst_len_r) << AXSIZE);
                     state_r <= final_beat_s ? ST_WAIT_B : ST_ADDR;
                  end
               end
            end
            ST_WAIT_B: begin
               if (outstanding_next_s == '0) begin
                  state_r <= ST_DONE;
               end
            end
            ST_DONE: begin
               status_valid_r    <= 1'b1;
               status_error_r    <= error_r;
               status_mismatch_r <= mismatch_r;
               bready_r          <= 1'b0;
               s_cmd_ready_r     <= 1'b1;
               state_r           <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign s_cmd_ready           = s_cmd_ready_r;
   assign s_axis_tready         = in_data_s && m_axi_wready;
   assign m_axi_awid            = ID_WIDTH'(AXI_ID);
   assign m_axi_awaddr          = awaddr_r;
   assign m_axi_awlen           = awlen_r;
   assign m_axi_awsize          = 3'(AXSIZE);
   assign m_axi_awburst         = BURST_INCR;
   assign m_axi_awlock          = 1'b0;
   assign m_axi_awcache         = AWCACHE_DEFAULT;
   assign m_axi_awprot          = 3'b000;
   assign m_axi_awvalid         = awvalid_r;
   assign m_axi_wdata           = s_axis_tdata;
   assign m_axi_wstrb           = s_axis_tkeep;
   assign m_axi_wlast           = in_data_s && (beat_cnt_r == 9'd1);
   assign m_axi_wvalid          = in_data_s && s_axis_tvalid;
   assign m_axi_bready          = bready_r;
   assign status_valid          = status_valid_r;
   assign status_error          = status_error_r;
   assign status_tlast_mismatch = status_mismatch_r;

endmodule

// File: tb/tb_axis_axi_ram_writer.sv
// Scoreboard bench: randomized commands, stream gaps and AXI slave stalls,
// checked against a plain-arithmetic model of burst splitting, data and status.
module tb_axis_axi_ram_writer;

   typedef struct packed { logic [15:0] addr; logic [7:0] len; } aw_t;
   typedef struct packed { logic [31:0] data; logic [3:0] strb; logic last; } beat_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] s_cmd_addr = 16'd0;
   logic [15:0] s_cmd_len = 16'd0;
   logic        s_cmd_valid = 1'b0;
   logic        s_cmd_ready;
   logic [31:0] s_axis_tdata = 32'd0;
   logic [3:0]  s_axis_tkeep = 4'd0;
   logic        s_axis_tlast = 1'b0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic [7:0]  m_axi_awid;
   logic [15:0] m_axi_awaddr;
   logic [7:0]  m_axi_awlen;
   logic [2:0]  m_axi_awsize;
   logic [1:0]  m_axi_awburst;
   logic        m_axi_awlock;
   logic [3:0]  m_axi_awcache;
   logic [2:0]  m_axi_awprot;
   logic        m_axi_awvalid;
   logic        m_axi_awready = 1'b0;
   logic [31:0] m_axi_wdata;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_wlast;
   logic        m_axi_wvalid;
   logic        m_axi_wready = 1'b0;
   logic [7:0]  m_axi_bid = 8'd0;
   logic [1:0]  m_axi_bresp = 2'b00;
   logic        m_axi_bvalid = 1'b0;
   logic        m_axi_bready;
   logic        status_valid;
   logic        status_error;
   logic        status_tlast_mismatch;

   always #5 clk = ~clk;

   axis_axi_ram_writer dut (
      .clk(clk), .rst(rst),
      .s_cmd_addr(s_cmd_addr), .s_cmd_len(s_cmd_len), .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
      .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
      .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
      .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .status_valid(status_valid), .status_error(status_error), .status_tlast_mismatch(status_tlast_mismatch)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int status_cnt = 0;
   int status_cyc = 0;
   int cmd_cyc = 0;
   int w_beats = 0;
   int w_idx = 0;

   aw_t         exp_aw_q[$];
   aw_t         act_aw_q[$];
   beat_t       exp_w_q[$];
   beat_t       src_q[$];
   logic [1:0]  exp_st_q[$];
   logic [1:0]  resp_plan_q[$];
   logic [1:0]  b_pend_q[$];
   logic [15:0] touch_q[$];
   logic [7:0]  mem [0:65535];
   logic [7:0]  exp_mem [0:65535];

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor on the falling edge, slave and stream drivers just after the rising edge.
   always begin : bus
      logic aw_f, w_f, b_f, s_f;
      aw_t e_aw;
      beat_t e_w;
      logic [1:0] e_st;
      logic [15:0] wa;
      @(negedge clk);
      aw_f = m_axi_awvalid && m_axi_awready;
      w_f  = m_axi_wvalid && m_axi_wready;
      b_f  = m_axi_bvalid && m_axi_bready;
      s_f  = s_axis_tvalid && s_axis_tready;
      if (!rst) begin
         if (s_cmd_valid && s_cmd_ready) cmd_cyc = cyc;
         if (aw_f) begin
            if (exp_aw_q.size() == 0) chk("aw_unexpected", 1, 0);
            else begin
               e_aw = exp_aw_q.pop_front();
               chk("aw_addr", m_axi_awaddr, e_aw.addr);
               chk("aw_len", m_axi_awlen, e_aw.len);
            end
            chk("aw_fields", {m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot},
                {8'h00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000});
            act_aw_q.push_back('{m_axi_awaddr, m_axi_awlen});
         end
         if (w_f) begin
            w_beats++;
            if (exp_w_q.size() == 0) chk("w_unexpected", 1, 0);
            else begin
               e_w = exp_w_q.pop_front();
               chk("w_data", m_axi_wdata, e_w.data);
               chk("w_strb", m_axi_wstrb, e_w.strb);
               chk("w_last", m_axi_wlast, e_w.last);
            end
            if (act_aw_q.size() == 0) chk("w_before_aw", 1, 0);
            else begin
               wa = act_aw_q[0].addr + 16'(w_idx * 4);
               for (int k = 0; k < 4; k++)
                  if (m_axi_wstrb[k]) mem[wa + 16'(k)] = m_axi_wdata[8*k +: 8];
               w_idx++;
               if (w_idx == int'(act_aw_q[0].len) + 1) begin
                  void'(act_aw_q.pop_front());
                  w_idx = 0;
                  if (resp_plan_q.size() > 0) b_pend_q.push_back(resp_plan_q.pop_front());
                  else b_pend_q.push_back(2'b00);
               end
            end
         end
         if (status_valid) begin
            status_cyc = cyc;
            status_cnt++;
            if (exp_st_q.size() == 0) chk("status_unexpected", 1, 0);
            else begin
               e_st = exp_st_q.pop_front();
               chk("status_error", status_error, e_st[1]);
               chk("status_mismatch", status_tlast_mismatch, e_st[0]);
            end
         end
      end
      @(posedge clk);
      #1;
      if (rst) begin
         exp_aw_q.delete(); act_aw_q.delete(); exp_w_q.delete(); src_q.delete();
         exp_st_q.delete(); resp_plan_q.delete(); b_pend_q.delete();
         w_idx = 0;
         s_axis_tvalid = 1'b0;
         m_axi_bvalid = 1'b0;
         m_axi_awready = 1'b0;
         m_axi_wready = 1'b0;
      end else begin
         if (b_f) begin
            m_axi_bvalid = 1'b0;
            void'(b_pend_q.pop_front());
         end else if (!m_axi_bvalid && b_pend_q.size() > 0 && $urandom_range(3) != 0) begin
            m_axi_bvalid = 1'b1;
            m_axi_bresp = b_pend_q[0];
         end
         m_axi_awready = ($urandom_range(3) != 0);
         m_axi_wready = ($urandom_range(3) != 0);
         if (s_f) void'(src_q.pop_front());
         if (!(s_axis_tvalid && !s_f)) begin
            if (src_q.size() > 0 && $urandom_range(3) != 0) begin
               s_axis_tvalid = 1'b1;
               s_axis_tdata = src_q[0].data;
               s_axis_tkeep = src_q[0].strb;
               s_axis_tlast = src_q[0].last;
            end else begin
               s_axis_tvalid = 1'b0;
            end
         end
      end
   end

   // last_mode: -1 tlast on the final beat, -2 random tlast bits, >=0 tlast only on that beat.
   task automatic issue_cmd(input logic [15:0] addr, input int len, input int last_mode, input int err_idx);
      int ai, rem, b, room, nb, i, ba;
      logic mis, tl, err;
      logic [31:0] d;
      logic [3:0] kp;
      ai = int'(addr) & 32'hFFFC;
      rem = len; nb = 0; i = 0; mis = 1'b0;
      touch_q.delete();
      while (rem > 0) begin
         room = (4096 - (ai % 4096)) / 4;
         b = rem;
         if (b > 16) b = 16;
         if (b > room) b = room;
         exp_aw_q.push_back('{16'(ai), 8'(b - 1)});
         for (int j = 0; j < b; j++) begin
            d = $urandom;
            kp = 4'($urandom);
            if (last_mode == -1) tl = (i == len - 1);
            else if (last_mode == -2) tl = ($urandom_range(3) == 0);
            else tl = (i == last_mode);
            if (tl != (i == len - 1)) mis = 1'b1;
            src_q.push_back('{d, kp, tl});
            exp_w_q.push_back('{d, kp, (j == b - 1)});
            ba = (ai + j * 4) % 65536;
            for (int k = 0; k < 4; k++)
               if (kp[k]) begin
                  exp_mem[16'(ba + k)] = d[8*k +: 8];
                  touch_q.push_back(16'(ba + k));
               end
            i++;
         end
         resp_plan_q.push_back((nb == err_idx) ? 2'b10 : 2'b00);
         nb++;
         ai = (ai + b * 4) % 65536;
         rem -= b;
      end
      err = (err_idx >= 0) && (err_idx < nb);
      exp_st_q.push_back({err, mis});
      @(posedge clk);
      #1;
      s_cmd_addr = addr;
      s_cmd_len = 16'(len);
      s_cmd_valid = 1'b1;
      begin : hs
         int t;
         for (t = 0; t < 200; t++) begin
            @(negedge clk);
            if (s_cmd_ready) break;
         end
         if (t == 200) chk("cmd_accept_timeout", 0, 1);
      end
      @(posedge clk);
      #1;
      s_cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int tgt);
      int errs;
      for (int i = 0; i < 4000 && status_cnt < tgt; i++) @(posedge clk);
      chk("status_arrived", status_cnt >= tgt, 1);
      if (touch_q.size() > 0) begin
         errs = 0;
         foreach (touch_q[n]) if (mem[touch_q[n]] !== exp_mem[touch_q[n]]) errs++;
         chk("mem_bytes", errs, 0);
      end
   endtask

   task automatic run_cmd(input logic [15:0] addr, input int len, input int last_mode, input int err_idx);
      int tgt;
      tgt = status_cnt + 1;
      issue_cmd(addr, len, last_mode, err_idx);
      wait_done(tgt);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ln;
      for (int a = 0; a < 65536; a++) begin
         mem[a] = 8'h00;
         exp_mem[a] = 8'h00;
      end
      #12;
      chk("reset_outputs", {s_cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, status_valid, s_axis_tready}, 6'b0);
      @(posedge clk); #2; rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("idle_cmd_ready", s_cmd_ready, 1);

      run_cmd(16'h0000, 20, -1, -1);
      run_cmd(16'h0FF0, 8, -1, -1);
      run_cmd(16'h0100, 0, -1, -1);
      chk("len0_latency", status_cyc - cmd_cyc, 2);
      run_cmd(16'h0400, 20, -1, 1);
      run_cmd(16'h2003, 37, 29, -1);
      run_cmd(16'hFFF8, 6, -1, -1);
      for (int r = 0; r < 8; r++) begin
         ln = $urandom_range(40, 1);
         run_cmd(16'($urandom), ln, ($urandom_range(3) == 0) ? -2 : -1,
                 ($urandom_range(1) == 0) ? int'($urandom_range(3)) : -1);
      end

      // Abort a 16-beat burst during its fifth beat.
      w_beats = 0;
      issue_cmd(16'h0200, 16, -1, -1);
      for (int i = 0; i < 2000 && w_beats < 4; i++) @(negedge clk);
      chk("reset_test_beat4", w_beats >= 4, 1);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("reset_drop", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_cmd_ready, status_valid}, 5'b0);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      run_cmd(16'h0800, 4, -1, -1);

      repeat (5) @(posedge clk);
      chk("queues_drained", exp_aw_q.size() + exp_w_q.size() + exp_st_q.size() + src_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/axis_axi_ram_writer.md
Name: axis_axi_ram_writer

Overview:
Upstream feeder for the AXI dual-port RAM. It accepts a write command (start address, beat count) and an AXI-stream payload, then issues AXI4 INCR write bursts to one RAM port. Bursts are split at MAX_BURST_LEN and at 4 KB boundaries. After all B responses return, it reports a one-cycle completion status.

Parameters:
DATA_WIDTH, 32, AXI/AXIS data width in bits; power of 2, at least 8.
ADDR_WIDTH, 16, AXI byte address width.
STRB_WIDTH, DATA_WIDTH/8, byte strobe / tkeep width.
ID_WIDTH, 8, AXI ID width.
AXI_ID, 0, constant value driven on awid.
LEN_WIDTH, 16, command beat-count width.
MAX_BURST_LEN, 16, maximum beats per burst; power of 2, range 1..256.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
s_cmd_addr  in  ADDR_WIDTH  start byte address; low log2(STRB_WIDTH) bits ignored (treated as 0)
s_cmd_len  in  LEN_WIDTH  beat count; 0 = no-op
s_cmd_valid / s_cmd_ready  in / out  1  command handshake
s_axis_tdata  in  DATA_WIDTH  payload
s_axis_tkeep  in  STRB_WIDTH  byte enables, passed to wstrb
s_axis_tlast  in  1  used only for mismatch detection
s_axis_tvalid / s_axis_tready  in / out  1  payload handshake
m_axi_awid, awaddr, awlen[7:0], awsize[2:0], awburst[1:0], awlock, awcache[3:0], awprot[2:0], awvalid  out; awready  in
m_axi_wdata, wstrb, wlast, wvalid  out; wready  in
m_axi_bid  in  ID_WIDTH (ignored); bresp  in  2; bvalid  in  1; bready  out  1
status_valid  out  1  one-cycle completion pulse
status_error  out  1  at least one bresp != OKAY
status_tlast_mismatch  out  1  tlast not seen exactly on the final beat

Behaviour:
- Reset is asynchronous and active-high; all registers clear. Reset values: s_cmd_ready 0, awvalid 0, wvalid 0, bready 0, status_* 0, state IDLE.
- Constant AW fields: awid=AXI_ID, awsize=log2(STRB_WIDTH), awburst=2'b01 (INCR), awlock=0, awcache=4'b0011, awprot=0.
- States:
  - IDLE: s_cmd_ready=1. On handshake, latch aligned address and remaining count, clear error and mismatch flags. len=0 goes to DONE; otherwise go to ADDR.
  - ADDR: compute burst = min(remaining, MAX_BURST_LEN, (4096 - addr[11:0]) / STRB_WIDTH). Present awvalid with awlen=burst-1; hold AW stable until awready. On handshake: outstanding_b++, load the beat counter, go to DATA.
  - DATA: wvalid=s_axis_tvalid, s_axis_tready=m_axi_wready (combinational pass-through, allowed only in DATA); wdata=tdata; wstrb=tkeep; wlast=(beat counter==1).
    - Each accepted beat decrements the beat counter and the remaining count.
    - Mismatch flag sets if tlast=1 on any beat other than the command's final beat, or tlast=0 on the final beat.
    - On the burst's last beat: address += burst*STRB_WIDTH; go to ADDR if remaining>0, else WAIT_B.
- bready=1 in every state except IDLE and reset.
  - Each B handshake decrements outstanding_b and ORs (bresp!=0) into the error flag.
  - A B handshake and an AW handshake in the same cycle leave the counter unchanged.
- WAIT_B: go to DONE when outstanding_b==0, including a B that arrives in the WAIT_B entry cycle.
- DONE: status_valid=1 for exactly one cycle with the flags valid; next state IDLE.
- Never more than one burst is in AW/W at a time; B responses may lag.
  - outstanding_b width: LEN_WIDTH+1 bits (bounded by the number of bursts).
- Stream stalls (tvalid low) or wready low hold everything; no timeout.
- Address wrap past 2^ADDR_WIDTH wraps modulo; 4 KB splitting still applies.
- Reset mid-burst: outputs drop immediately. Any partial AXI transaction is abandoned; the slave must be reset together with this block.

Decomposition:
- Shared package: AXI constants (BURST_INCR, RESP_OKAY, AWCACHE default) and the state encoding (IDLE, ADDR, DATA, WAIT_B, DONE).
- Burst-size calculation stays inline in this module; it is a single expression.
- No sub-module is required.

Test Plan:
- addr 0x0000, len 20, MAX 16 -> AW 0x0000 awlen 15, then AW 0x0040 awlen 3; wlast on beats 16 and 20; status_valid with error=0, mismatch=0.
- addr 0x0FF0, len 8 -> AW 0x0FF0 awlen 3, then AW 0x1000 awlen 3; data read back through port B matches.
- len 0 -> no AW; status_valid exactly 2 cycles after the cmd handshake.
- len 20, second burst bresp=2'b10 -> status_error=1; RAM contents of the first burst correct.
- Random tvalid/wready/awready/bvalid gaps with len 37 -> 37 beats in order, no lost or duplicate beats; tlast on beat 30 only -> status_tlast_mismatch=1.
- Assert rst during beat 5 of a 16-beat burst -> awvalid=wvalid=bready=0 immediately; after release, a new len 4 command completes normally.
